// File: rtl/bc_disp_pkg.sv
// bc_disp_pkg: glyph codes, phase/state encodings and digit-word packing for the message formatter
package bc_disp_pkg;

    localparam logic [4:0] G_J     = 5'h05;
    localparam logic [4:0] G_S     = 5'h06;
    localparam logic [4:0] G_E     = 5'h07;
    localparam logic [4:0] G_T     = 5'h08;
    localparam logic [4:0] G_U     = 5'h09;
    localparam logic [4:0] G_P     = 5'h0A;
    localparam logic [4:0] G_B     = 5'h0B;
    localparam logic [4:0] G_C     = 5'h0C;
    localparam logic [4:0] G_L     = 5'h0D;
    localparam logic [4:0] G_BLANK = 5'h10;

    localparam logic [6:0] OFF_WORD = 7'b0_10000_1;

    typedef enum logic [1:0] {PH_OFF, PH_SETUP, PH_GUESS, PH_WIN} phase_t;
    typedef enum logic [2:0] {ST_OFF, ST_SETUP, ST_GUESS, ST_RESULT, ST_WIN} state_t;

    function automatic logic [6:0] pack(input logic en, input logic [4:0] code, input logic dp_n);
        return {en, code, dp_n};
    endfunction

    function automatic logic [6:0] lit(input logic [4:0] code);
        return pack(1'b1, code, 1'b1);
    endfunction

    function automatic logic [4:0] glyph_of(input logic [2:0] v);
        return (v <= 3'd4) ? {2'b00, v} : G_BLANK;
    endfunction

endpackage

// File: rtl/bc_blink_timer.sv
// bc_blink_timer: blink half-period counter with visible-on-clear phase and a toggle strobe
module bc_blink_timer #(
    parameter int HALF = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic blink_phase,
    output logic tick
);

    localparam int W = $clog2(HALF);

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(HALF - 1));

    // count half-periods; a clear restarts the period with the display visible
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (clear) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (tick) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/bc_msg_fmt.sv
// bc_msg_fmt: builds the eight display digit words from game state, with result hold and blinking
module bc_msg_fmt
    import bc_disp_pkg::*;
#(
    parameter int BLINK_HALF_CYCLES  = 25_000_000,
    parameter int RESULT_HOLD_BLINKS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] phase,
    input  logic       player,
    input  logic [2:0] g0,
    input  logic [2:0] g1,
    input  logic [2:0] g2,
    input  logic [2:0] g3,
    input  logic [2:0] n_entered,
    input  logic       result_valid,
    input  logic [2:0] bulls,
    input  logic [2:0] cows,
    output logic [6:0] d1,
    output logic [6:0] d2,
    output logic [6:0] d3,
    output logic [6:0] d4,
    output logic [6:0] d5,
    output logic [6:0] d6,
    output logic [6:0] d7,
    output logic [6:0] d8,
    output logic       result_active
);

    localparam int HW = $clog2(RESULT_HOLD_BLINKS + 1);

    phase_t          ph;
    state_t          state, next_state;
    logic            relatch, hold_done, clear, blink_phase, tick;
    logic [HW-1:0]   hold_cnt;
    logic [2:0]      bulls_q, cows_q, ne;
    logic [4:0]      pn;
    logic [2:0]      gv [4];
    logic [6:0]      gd [4];
    logic [6:0]      f [8:1];
    logic [6:0]      q [8:1];

    assign ph        = phase_t'(phase);
    assign relatch   = result_valid && ph == PH_GUESS && (state == ST_GUESS || state == ST_RESULT);
    assign hold_done = tick && hold_cnt == HW'(RESULT_HOLD_BLINKS - 1);
    assign clear     = (next_state != state) || (state == ST_RESULT && relatch);
    assign pn        = player ? 5'h02 : 5'h01;
    assign ne        = (n_entered > 3'd4) ? 3'd4 : n_entered;

    bc_blink_timer #(.HALF(BLINK_HALF_CYCLES)) u_blink (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .blink_phase (blink_phase),
        .tick        (tick)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_OFF;
        else        state <= next_state;
    end

    // phase picks the state; only GUESS/RESULT move between each other internally
    always_comb begin
        next_state = ST_OFF;
        next_state = (ph == PH_OFF)   ? ST_OFF   :
                     (ph == PH_SETUP) ? ST_SETUP :
                     (ph == PH_WIN)   ? ST_WIN   :
                     (relatch || (state == ST_RESULT && !hold_done)) ? ST_RESULT : ST_GUESS;
    end

    // hold counter counts blink toggles in RESULT and latched counts follow each accepted strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            bulls_q  <= '0;
            cows_q   <= '0;
        end else begin
            hold_cnt <= clear ? '0 : (state == ST_RESULT && tick) ? hold_cnt + HW'(1) : hold_cnt;
            if (relatch) begin
                bulls_q <= bulls;
                cows_q  <= cows;
            end
        end
    end

    // guess digits: entered ones shown, the cursor slot blinks its dot, the rest blank
    always_comb begin
        gv = '{g0, g1, g2, g3};
        for (int k = 0; k < 4; k++)
            gd[k] = (3'(k) < ne) ? lit(glyph_of(gv[k])) :
                    pack(1'b1, G_BLANK, (3'(k) == ne) ? ~blink_phase : 1'b1);
    end

    // frame selection, d8 first
    always_comb begin
        f = '{default: OFF_WORD};
        unique case (state)
            ST_SETUP:  f = '{lit(G_J), lit(pn), lit(G_BLANK), lit(G_S), lit(G_E), lit(G_T), lit(G_U), lit(G_P)};
            ST_GUESS:  f = '{lit(G_J), lit(pn), lit(G_BLANK), lit(G_BLANK), gd[0], gd[1], gd[2], gd[3]};
            ST_RESULT: f = '{lit(G_J), lit(pn), lit(G_BLANK), lit(glyph_of(bulls_q)), lit(G_B),
                             lit(G_BLANK), lit(glyph_of(cows_q)), lit(G_C)};
            ST_WIN:    f = '{pack(blink_phase, G_J, 1'b1), pack(blink_phase, pn, 1'b1),
                             pack(blink_phase, G_BLANK, 1'b1), pack(blink_phase, G_B, 1'b1),
                             pack(blink_phase, G_U, 1'b1), pack(blink_phase, G_L, 1'b1),
                             pack(blink_phase, G_L, 1'b1), pack(blink_phase, G_S, 1'b1)};
            default:   f = '{default: OFF_WORD};
        endcase
    end

    // register the frame and the result flag together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q             <= '{default: OFF_WORD};
            result_active <= 1'b0;
        end else begin
            q             <= f;
            result_active <= (state == ST_RESULT);
        end
    end

    assign d8 = q[8];
    assign d7 = q[7];
    assign d6 = q[6];
    assign d5 = q[5];
    assign d4 = q[4];
    assign d3 = q[3];
    assign d2 = q[2];
    assign d1 = q[1];

endmodule

// File: tb/tb_bc_msg_fmt.sv
// tb_bc_msg_fmt: scoreboard bench for the display message formatter
module tb_bc_msg_fmt;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] phase = 2'd0;
    logic       player = 1'b0;
    logic [2:0] g0 = 3'd0, g1 = 3'd0, g2 = 3'd0, g3 = 3'd0, n_entered = 3'd0;
    logic       result_valid = 1'b0;
    logic [2:0] bulls = 3'd0, cows = 3'd0;
    logic [6:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       result_active;

    int          tests = 0;
    int          fails = 0;
    logic [56:0] sb [$];
    logic [56:0] exp_v;
    wire  [56:0] obs = {d8, d7, d6, d5, d4, d3, d2, d1, result_active};

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    bc_msg_fmt #(.BLINK_HALF_CYCLES(4), .RESULT_HOLD_BLINKS(2)) dut (
        .clock(clock), .reset(reset), .phase(phase), .player(player),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3), .n_entered(n_entered),
        .result_valid(result_valid), .bulls(bulls), .cows(cows),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .result_active(result_active)
    );

    function automatic logic [6:0] dg(input logic en, input logic [4:0] c, input logic dpn);
        return {en, c, dpn};
    endfunction

    function automatic logic [56:0] fr_off();
        return {{8{7'h21}}, 1'b0};
    endfunction

    function automatic logic [56:0] fr_setup(input logic p);
        return {dg(1, 5'h05, 1), dg(1, p ? 5'h02 : 5'h01, 1), dg(1, 5'h10, 1), dg(1, 5'h06, 1),
                dg(1, 5'h07, 1), dg(1, 5'h08, 1), dg(1, 5'h09, 1), dg(1, 5'h0A, 1), 1'b0};
    endfunction

    function automatic logic [56:0] fr_guess(input logic p, input int n, input logic [2:0] a, b, c, e,
                                            input logic dp);
        logic [2:0] g [4];
        logic [6:0] w [4];
        int ne;
        g  = '{a, b, c, e};
        ne = (n > 4) ? 4 : n;
        for (int k = 0; k < 4; k++)
            w[k] = (k < ne) ? dg(1, (g[k] > 3'd4) ? 5'h10 : {2'b00, g[k]}, 1) :
                   (k == ne) ? dg(1, 5'h10, dp) : dg(1, 5'h10, 1);
        return {dg(1, 5'h05, 1), dg(1, p ? 5'h02 : 5'h01, 1), dg(1, 5'h10, 1), dg(1, 5'h10, 1),
                w[0], w[1], w[2], w[3], 1'b0};
    endfunction

    function automatic logic [56:0] fr_result(input logic p, input logic [2:0] b, input logic [2:0] c);
        return {dg(1, 5'h05, 1), dg(1, p ? 5'h02 : 5'h01, 1), dg(1, 5'h10, 1),
                dg(1, (b > 3'd4) ? 5'h10 : {2'b00, b}, 1), dg(1, 5'h0B, 1), dg(1, 5'h10, 1),
                dg(1, (c > 3'd4) ? 5'h10 : {2'b00, c}, 1), dg(1, 5'h0C, 1), 1'b1};
    endfunction

    function automatic logic [56:0] fr_win(input logic p, input logic en);
        return {dg(en, 5'h05, 1), dg(en, p ? 5'h02 : 5'h01, 1), dg(en, 5'h10, 1), dg(en, 5'h0B, 1),
                dg(en, 5'h09, 1), dg(en, 5'h0D, 1), dg(en, 5'h0D, 1), dg(en, 5'h06, 1), 1'b0};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        sb.push_back(fr_off());
        sb.push_back(fr_off());
        #12;
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_setup();
        phase  = 2'd1;
        player = 1'b0;
        sb.push_back(fr_off());
        sb.push_back(fr_setup(1'b0));
        for (int i = 0; i < 2; i++) begin
            step();
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL setup[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_guess();
        phase = 2'd2; n_entered = 3'd2; g0 = 3'd3; g1 = 3'd4; g2 = 3'd1; g3 = 3'd2;
        step();
        for (int i = 0; i < 12; i++)
            sb.push_back(fr_guess(1'b0, 2, 3'd3, 3'd4, 3'd1, 3'd2, ((i / 4) % 2) == 1));
        for (int i = 0; i < 12; i++) begin
            step();
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL guess_cursor[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        n_entered = 3'd4; g2 = 3'd5;
        sb.push_back(fr_guess(1'b0, 4, 3'd3, 3'd4, 3'd5, 3'd2, 1'b1));
        step();
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL guess_full: got %h expected %h", obs, exp_v);
        end
        n_entered = 3'd7;
        sb.push_back(fr_guess(1'b0, 4, 3'd3, 3'd4, 3'd5, 3'd2, 1'b1));
        step();
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL guess_clamp: got %h expected %h", obs, exp_v);
        end
        n_entered = 3'd2; g2 = 3'd1;
    endtask

    task automatic test_result();
        bulls = 3'd2; cows = 3'd1; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back(fr_result(1'b0, 3'd2, 3'd1));
        sb.push_back(fr_guess(1'b0, 2, 3'd3, 3'd4, 3'd1, 3'd2, 1'b0));
        for (int i = 0; i < 9; i++) begin
            step();
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL result_hold[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        bulls = 3'd2; cows = 3'd1; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(fr_result(1'b0, 3'd2, 3'd1));
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b2b_first[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        bulls = 3'd3; result_valid = 1'b1;
        sb.push_back(fr_result(1'b0, 3'd2, 3'd1));
        for (int i = 0; i < 8; i++) sb.push_back(fr_result(1'b0, 3'd3, 3'd1));
        sb.push_back(fr_guess(1'b0, 2, 3'd3, 3'd4, 3'd1, 3'd2, 1'b0));
        for (int i = 0; i < 10; i++) begin
            step();
            result_valid = 1'b0;
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL b2b_relatch[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_win();
        bulls = 3'd2; cows = 3'd1; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        sb.push_back(fr_result(1'b0, 3'd2, 3'd1));
        sb.push_back(fr_result(1'b0, 3'd2, 3'd1));
        for (int i = 0; i < 12; i++) sb.push_back(fr_win(1'b0, ((i / 4) % 2) == 0));
        for (int i = 0; i < 14; i++) begin
            step();
            phase = 2'd3;
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL win[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        sb.push_back(fr_off());
        #2;
        reset = 1'b0;
        #1;
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_ignored();
        phase = 2'd1; player = 1'b1;
        step();
        bulls = 3'd2; cows = 3'd2; result_valid = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(fr_setup(1'b1));
        for (int i = 0; i < 3; i++) begin
            step();
            result_valid = 1'b0;
            exp_v = sb.pop_front();
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL setup_ignore[%0d]: got %h expected %h", i, obs, exp_v);
            end
        end
        phase = 2'd2; n_entered = 3'd0;
        step();
        bulls = 3'd6; cows = 3'd4; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        sb.push_back(fr_result(1'b1, 3'd6, 3'd4));
        step();
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL result_blank: got %h expected %h", obs, exp_v);
        end
        phase = 2'd1; bulls = 3'd1; result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        sb.push_back(fr_setup(1'b1));
        step();
        exp_v = sb.pop_front();
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL phase_wins: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_guess();
        test_result();
        test_back_to_back();
        test_win();
        test_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
